led_step_ctrl: RTL

- Enable-pulse generator that drives the `en` input of the reconfigurable LED pattern modules (shift/rotate/count variants) in the static region.
- Produces single-cycle `en` strobes in one of two modes:
  - free-running at a selectable period;
  - one strobe per debounced push-button press.
- Exports a strobe counter for status readback.

---
 rtl/led_step_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: en-strobe generator for the LED pattern modules.
// Free-run at a selectable period or one strobe per debounced button press.
// Ports: clk; reset (async, active-low); run, step_btn (async inputs);
//   div_sel[1:0] period select; en strobe; running (in RUN); tick_cnt[7:0].
// Macro LED_STEP_AUTORUN_EN: reset into RUN, hold until run is first seen high.
module led_step_ctrl #(
  parameter int CNT_W      = 27,
  parameter int DIV0       = 12_500_000,
  parameter int DIV1       = 25_000_000,
  parameter int DIV2       = 50_000_000,
  parameter int DIV3       = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step_btn,
  input  logic [1:0] div_sel,
  output logic       en,
  output logic       running,
  output logic [7:0] tick_cnt
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_STEP
  } state_t;

  // A zero divider would never wrap; clamp to one cycle.
  localparam int D0 = (DIV0 < 1) ? 1 : DIV0;
  localparam int D1 = (DIV1 < 1) ? 1 : DIV1;
  localparam int D2 = (DIV2 < 1) ? 1 : DIV2;
  localparam int D3 = (DIV3 < 1) ? 1 : DIV3;
  localparam int DB = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;

  localparam logic [CNT_W-1:0] P0 = CNT_W'(D0);
  localparam logic [CNT_W-1:0] P1 = CNT_W'(D1);
  localparam logic [CNT_W-1:0] P2 = CNT_W'(D2);
  localparam logic [CNT_W-1:0] P3 = CNT_W'(D3);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DB - 1);

`ifdef LED_STEP_AUTORUN_EN
  localparam state_t RST_STATE = ST_RUN;
  localparam logic   RST_RUN   = 1'b1;
`else
  localparam state_t RST_STATE = ST_STOP;
  localparam logic   RST_RUN   = 1'b0;
`endif

  logic             run_meta;
  logic             run_s;
  logic             step_meta;
  logic             step_s;
  logic             step_db;
  logic             step_req;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_hit;
  logic             run_drop;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_nx;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_nx;
  logic [CNT_W-1:0] div_val;
  logic             wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
    end else begin
      run_meta  <= run;
      run_s     <= run_meta;
      step_meta <= step_btn;
      step_s    <= step_meta;
    end
  end

  assign deb_hit = (step_s != step_db) &&
                   (deb_cnt == DEB_LAST);

  // step_req rises together with step_db on an accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_db  <= 1'b0;
      deb_cnt  <= '0;
      step_req <= 1'b0;
    end else begin
      step_req <= deb_hit & step_s;
      if (step_s == step_db) begin
        deb_cnt <= '0;
      end else if (deb_hit) begin
        deb_cnt <= '0;
        step_db <= step_s;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

`ifdef LED_STEP_AUTORUN_EN
  logic run_seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_seen <= 1'b0;
    end else if (run_s) begin
      run_seen <= 1'b1;
    end
  end

  // Low run is only honoured once run has been high.
  assign run_drop = ~run_s & run_seen;
`else
  assign run_drop = ~run_s;
`endif

  always_comb begin
    div_val = P0;
    unique case (div_sel)
      2'd0: div_val = P0;
      2'd1: div_val = P1;
      2'd2: div_val = P2;
      2'd3: div_val = P3;
      default: div_val = P0;
    endcase
  end

  assign wrap = (presc == period - 1'b1);

  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    period_nx = period;
    en        = 1'b0;
    unique case (state)
      ST_STOP: begin
        presc_nx  = '0;
        period_nx = div_val;
        if (run_s) begin
          state_nx = ST_RUN;
        end else if (step_req) begin
          state_nx = ST_STEP;
        end
      end
      ST_RUN: begin
        if (run_drop) begin
          state_nx = ST_STOP;
          presc_nx = '0;
        end else if (wrap) begin
          en        = 1'b1;
          presc_nx  = '0;
          period_nx = div_val;
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      ST_STEP: begin
        en       = 1'b1;
        presc_nx = '0;
        state_nx = ST_STOP;
      end
      default: begin
        state_nx = ST_STOP;
        presc_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RST_STATE;
      presc    <= '0;
      period   <= P0;
      running  <= RST_RUN;
      tick_cnt <= '0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      period   <= period_nx;
      running  <= (state_nx == ST_RUN);
      tick_cnt <= tick_cnt + {7'd0, en};
    end
  end

endmodule
